// File: rtl/cmd_decoder.sv
// Byte-stream command decoder: SYNC, {wr,rsvd,a_hi}, a_lo, data, checksum -> one bus command.
// Latency: command valid (out_stb) the cycle after the checksum byte is accepted.
// Backpressure: in_ack drops while a command waits for out_ack; outputs hold until out_ack.
module cmd_decoder #(
    parameter logic [7:0]  SYNC_BYTE = 8'h55,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_stb,
    output logic        in_ack,
    input  logic [7:0]  in_d,
    output logic        out_stb,
    input  logic        out_ack,
    output logic        out_wr,
    output logic [13:0] out_a,
    output logic [7:0]  out_d,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_ADRH,
        S_ADRL,
        S_DATA,
        S_CSUM,
        S_ISSUE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] idle_q, idle_d;
    logic [7:0]  err_q, err_d;
    logic        stb_q, stb_d;
    logic        wr_q, wr_d;
    logic [13:0] a_q, a_d;
    logic [7:0]  dat_q, dat_d;

    logic        acc;
    logic [7:0]  err_inc;
    logic        idle_expired;

    // Input is accepted in every state except ISSUE; forced low while reset is held so the
    // first cycle after reset release already accepts.
    assign in_ack       = ~rst && (state_q != S_ISSUE);
    assign acc          = in_stb && in_ack;
    assign err_inc      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    assign idle_expired = (idle_q == TIMEOUT - 16'd1);

    assign out_stb = stb_q;
    assign out_wr  = wr_q;
    assign out_a   = a_q;
    assign out_d   = dat_q;
    assign err_cnt = err_q;

    // Next-state decode: byte parsing, checksum compare, idle timeout and command handshake.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        idle_d  = 16'd0;
        err_d   = err_q;
        stb_d   = stb_q;
        wr_d    = wr_q;
        a_d     = a_q;
        dat_d   = dat_q;
        case (state_q)
            S_SYNC: begin
                if (acc && (in_d == SYNC_BYTE)) begin
                    state_d = S_ADRH;
                    sum_d   = in_d;
                end
            end
            S_ADRH, S_ADRL, S_DATA, S_CSUM: begin
                if (acc) begin
                    // A byte in the same cycle as expiry wins; idle_d stays 0.
                    sum_d = sum_q + in_d;
                    case (state_q)
                        S_ADRH: begin
                            wr_d       = in_d[7];
                            a_d[13:8]  = in_d[5:0];
                            state_d    = S_ADRL;
                        end
                        S_ADRL: begin
                            a_d[7:0] = in_d;
                            state_d  = S_DATA;
                        end
                        S_DATA: begin
                            // Reads always present zero data.
                            dat_d   = wr_q ? in_d : 8'h00;
                            state_d = S_CSUM;
                        end
                        default: begin
                            if (in_d == sum_q) begin
                                state_d = S_ISSUE;
                                stb_d   = 1'b1;
                            end else begin
                                state_d = S_SYNC;
                                err_d   = err_inc;
                            end
                        end
                    endcase
                end else if (idle_expired) begin
                    state_d = S_SYNC;
                    err_d   = err_inc;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            S_ISSUE: begin
                if (out_ack) begin
                    state_d = S_SYNC;
                    stb_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_SYNC;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SYNC;
            sum_q   <= 8'h00;
            idle_q  <= 16'd0;
            err_q   <= 8'h00;
            stb_q   <= 1'b0;
            wr_q    <= 1'b0;
            a_q     <= 14'd0;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            stb_q   <= stb_d;
            wr_q    <= wr_d;
            a_q     <= a_d;
            dat_q   <= dat_d;
        end
    end

endmodule

// File: tb/tb_cmd_decoder.sv
// Bench for cmd_decoder: directed packets plus randomized byte streams against a packet-level model.
// Latency: model predicts out_stb the cycle after a good checksum byte.
// Backpressure: model predicts in_ack low while a command is pending.
module tb_cmd_decoder;

    localparam logic [7:0] SYNC = 8'h55;
    localparam int         TMO  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_stb = 1'b0;
    logic        in_ack;
    logic [7:0]  in_d = 8'h00;
    logic        out_stb;
    logic        out_ack = 1'b0;
    logic        out_wr;
    logic [13:0] out_a;
    logic [7:0]  out_d;
    logic [7:0]  err_cnt;

    cmd_decoder #(
        .SYNC_BYTE(SYNC),
        .TIMEOUT  (16'(TMO))
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .in_stb (in_stb),
        .in_ack (in_ack),
        .in_d   (in_d),
        .out_stb(out_stb),
        .out_ack(out_ack),
        .out_wr (out_wr),
        .out_a  (out_a),
        .out_d  (out_d),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Packet-level reference model: bytes collected since the sync byte, idle cycles, pending command.
    logic [7:0]  pkt[$];
    int          m_idle  = 0;
    logic        m_issue = 1'b0;
    logic [7:0]  m_err   = 8'h00;
    logic        m_wr    = 1'b0;
    logic [13:0] m_a     = 14'd0;
    logic [7:0]  m_d     = 8'h00;

    logic [22:0] obs[$];
    logic        last_acc = 1'b0;
    logic        rand_ack = 1'b0;
    logic        ack_lvl  = 1'b1;

    logic [22:0] cmd_wr_1234 = {1'b1, 14'h1234, 8'hAB};
    logic [22:0] cmd_rd_0010 = {1'b0, 14'h0010, 8'h00};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic pick_ack();
        if (rand_ack) return ($urandom_range(0, 3) != 0);
        return ack_lvl;
    endfunction

    // One clock cycle: drive, check the cycle's outputs against the model, then advance the model.
    task automatic step(input logic stb, input logic [7:0] d, input logic ack, input logic r);
        logic       exp_ack;
        logic [7:0] s;
        @(negedge clk);
        rst = r; in_stb = stb; in_d = d; out_ack = ack;
        #1;
        exp_ack = !r && !m_issue;
        check_eq("in_ack", 32'(in_ack), 32'(exp_ack));
        check_eq("out_stb", 32'(out_stb), 32'(m_issue));
        check_eq("err_cnt", 32'(err_cnt), 32'(m_err));
        if (m_issue) begin
            check_eq("cmd_wr", 32'(out_wr), 32'(m_wr));
            check_eq("cmd_a", 32'(out_a), 32'(m_a));
            check_eq("cmd_d", 32'(out_d), 32'(m_d));
        end
        if (out_stb && ack && !r) obs.push_back({out_wr, out_a, out_d});
        last_acc = stb && exp_ack;
        @(posedge clk);
        if (r) begin
            pkt.delete(); m_idle = 0; m_issue = 1'b0; m_err = 8'h00;
        end else if (m_issue) begin
            if (ack) m_issue = 1'b0;
        end else if (stb) begin
            m_idle = 0;
            if (pkt.size() == 0) begin
                if (d == SYNC) pkt.push_back(d);
            end else begin
                pkt.push_back(d);
                if (pkt.size() == 5) begin
                    s = pkt[0] + pkt[1] + pkt[2] + pkt[3];
                    if (s == pkt[4]) begin
                        m_issue = 1'b1;
                        m_wr    = pkt[1][7];
                        m_a     = {pkt[1][5:0], pkt[2]};
                        m_d     = pkt[1][7] ? pkt[3] : 8'h00;
                    end else begin
                        m_err = sat_inc(m_err);
                    end
                    pkt.delete();
                end
            end
        end else if (pkt.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                pkt.delete(); m_idle = 0; m_err = sat_inc(m_err);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        do begin
            step(1'b1, b, pick_ack(), 1'b0);
            n++;
        end while (!last_acc && n < 200);
        check_eq("byte_accept_wait", 32'(last_acc), 32'd1);
    endtask

    task automatic send5(input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, pick_ack(), 1'b0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0, 1'b1);
        obs.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b1, b2, b3, cs;
        int mode;

        // Reset values
        do_reset(3);
        #2;
        check_eq("rst_in_ack", 32'(in_ack), 32'd0);
        check_eq("rst_out_stb", 32'(out_stb), 32'd0);
        check_eq("rst_out_wr", 32'(out_wr), 32'd0);
        check_eq("rst_out_a", 32'(out_a), 32'd0);
        check_eq("rst_out_d", 32'(out_d), 32'd0);
        check_eq("rst_err", 32'(err_cnt), 32'd0);

        // Write command
        send5(8'h55, 8'h92, 8'h34, 8'hAB, 8'hC6);
        idle(3);
        check_eq("wr_count", obs.size(), 32'd1);
        if (obs.size() > 0) check_eq("wr_cmd", 32'(obs[0]), 32'(cmd_wr_1234));
        check_eq("wr_err", 32'(err_cnt), 32'd0);
        obs.delete();

        // Read command
        send5(8'h55, 8'h00, 8'h10, 8'h00, 8'h65);
        idle(3);
        check_eq("rd_count", obs.size(), 32'd1);
        if (obs.size() > 0) check_eq("rd_cmd", 32'(obs[0]), 32'(cmd_rd_0010));
        obs.delete();

        // Bad checksum, then recovery
        send5(8'h55, 8'h92, 8'h34, 8'hAB, 8'h00);
        idle(2);
        check_eq("badcs_count", obs.size(), 32'd0);
        check_eq("badcs_err", 32'(err_cnt), 32'd1);
        send5(8'h55, 8'h00, 8'h10, 8'h00, 8'h65);
        idle(3);
        check_eq("badcs_recover", obs.size(), 32'd1);
        if (obs.size() > 0) check_eq("badcs_rd_cmd", 32'(obs[0]), 32'(cmd_rd_0010));
        obs.delete();

        // Leading garbage
        send_byte(8'h00); send_byte(8'hFF);
        send5(8'h55, 8'h00, 8'h10, 8'h00, 8'h65);
        idle(3);
        check_eq("garbage_count", obs.size(), 32'd1);
        if (obs.size() > 0) check_eq("garbage_cmd", 32'(obs[0]), 32'(cmd_rd_0010));

        // Timeout discards the partial packet
        do_reset(2);
        send_byte(8'h55); send_byte(8'h92);
        idle(TMO);
        #2;
        check_eq("tmo_err", 32'(err_cnt), 32'd1);
        send5(8'h55, 8'h00, 8'h10, 8'h00, 8'h65);
        idle(3);
        check_eq("tmo_recover", obs.size(), 32'd1);
        if (obs.size() > 0) check_eq("tmo_rd_cmd", 32'(obs[0]), 32'(cmd_rd_0010));

        // Byte arriving on the last allowed idle cycle keeps the packet alive
        do_reset(2);
        send_byte(8'h55); send_byte(8'h92);
        idle(TMO - 1);
        send_byte(8'h34); send_byte(8'hAB); send_byte(8'hC6);
        idle(3);
        check_eq("edge_err", 32'(err_cnt), 32'd0);
        check_eq("edge_count", obs.size(), 32'd1);
        if (obs.size() > 0) check_eq("edge_cmd", 32'(obs[0]), 32'(cmd_wr_1234));
        obs.delete();

        // Backpressure, then back-to-back packet
        ack_lvl = 1'b0;
        send5(8'h55, 8'h00, 8'h10, 8'h00, 8'h65);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            #2;
            check_eq("bp_out_stb", 32'(out_stb), 32'd1);
            check_eq("bp_in_ack", 32'(in_ack), 32'd0);
            check_eq("bp_out_a", 32'(out_a), 32'h0010);
            check_eq("bp_out_wr", 32'(out_wr), 32'd0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        #2;
        check_eq("bp_release_in_ack", 32'(in_ack), 32'd1);
        check_eq("bp_release_stb", 32'(out_stb), 32'd0);
        ack_lvl = 1'b1;
        send5(8'h55, 8'h92, 8'h34, 8'hAB, 8'hC6);
        idle(3);
        check_eq("b2b_count", obs.size(), 32'd2);
        if (obs.size() > 1) check_eq("b2b_cmd", 32'(obs[1]), 32'(cmd_wr_1234));

        // Reset mid-packet and during a pending command
        obs.delete();
        send_byte(8'h55); send_byte(8'h92); send_byte(8'h34);
        do_reset(2);
        send_byte(8'hAB); send_byte(8'hC6);
        idle(3);
        check_eq("rst_mid_count", obs.size(), 32'd0);
        ack_lvl = 1'b0;
        send5(8'h55, 8'h00, 8'h10, 8'h00, 8'h65);
        idle(2);
        do_reset(2);
        ack_lvl = 1'b1;
        idle(3);
        check_eq("rst_issue_count", obs.size(), 32'd0);

        // Error counter saturation
        repeat (260) send5(8'h55, 8'h00, 8'h00, 8'h00, 8'h00);
        #2;
        check_eq("err_saturate", 32'(err_cnt), 32'hFF);

        // Randomized stream
        do_reset(2);
        rand_ack = 1'b1;
        for (int p = 0; p < 300; p++) begin
            mode = $urandom_range(0, 9);
            b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
            if (mode == 9) b3 = SYNC;
            cs = SYNC + b1 + b2 + b3;
            if (mode == 6) cs = cs ^ 8'($urandom_range(1, 255));
            if (mode == 7) begin
                send_byte(8'($urandom));
            end else if (mode == 8) begin
                send_byte(SYNC); send_byte(b1);
                if ($urandom_range(0, 1) == 1) send_byte(b2);
                idle(TMO + 5);
            end else begin
                send_byte(SYNC); idle($urandom_range(0, 2));
                send_byte(b1);   idle($urandom_range(0, 2));
                send_byte(b2);   idle($urandom_range(0, 2));
                send_byte(b3);   idle($urandom_range(0, 2));
                send_byte(cs);
            end
            idle($urandom_range(0, 3));
        end
        rand_ack = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
